// File: rtl/pdp8_pkg.sv
// Shared PDP-8 CPU definitions.
// Major-state codes and tick counter sizing.
package pdp8_pkg;

  typedef enum logic [2:0] {
    MS_IDLE     = 3'd0,
    MS_FETCH    = 3'd1,
    MS_AUTOINC1 = 3'd2,
    MS_AUTOINC2 = 3'd3,
    MS_INDIRECT = 3'd4,
    MS_EXEC     = 3'd5
  } major_state_e;

  localparam int TICKS_DEFAULT = 4;
  localparam int TICKS_MAX     = 8;
  localparam int TICK_W        = $clog2(TICKS_MAX);

endpackage

// File: rtl/major_cycle_seq_phase_counter.sv
// Tick counter within one major cycle.
// Decodes drive, latch and dead-tick phases.
module phase_counter
  import pdp8_pkg::*;
#(
  parameter int TICKS = TICKS_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic ckPhase,
  output logic stbPhase,
  output logic lastTick
);

  localparam logic [TICK_W-1:0] LAST = TICK_W'(TICKS - 1);
  localparam logic [TICK_W-1:0] STB  = TICK_W'(TICKS - 2);

  logic [TICK_W-1:0] tick_d;
  logic [TICK_W-1:0] tick_q;

  // advance the tick, wrapping at the dead tick or on restart
  always_comb begin
    tick_d = tick_q + TICK_W'(1);
    if (restart || tick_q == LAST) begin
      tick_d = '0;
    end
  end

  // tick register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_q <= '0;
    end else begin
      tick_q <= tick_d;
    end
  end

  assign ckPhase  = (tick_q < LAST);
  assign stbPhase = (tick_q == STB);
  assign lastTick = (tick_q == LAST);

endmodule

// File: rtl/major_cycle_seq.sv
// PDP-8 major-cycle sequencer.
// Steps FETCH/AUTOINC/INDIRECT/EXEC and fans out strobes.
module major_cycle_seq
  import pdp8_pkg::*;
#(
  parameter int TICKS = TICKS_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       step,
  input  logic       instIsIND,
  input  logic       instIsPPIND,
  output logic       ckFetch,
  output logic       stbFetch,
  output logic       ckAutoinc1,
  output logic       stbAutoinc1,
  output logic       ckAutoinc2,
  output logic       stbAutoinc2,
  output logic       ckIndirect,
  output logic       stbIndirect,
  output logic       ckExec,
  output logic       stbExec,
  output logic [2:0] majorState,
  output logic       busy,
  output logic       instDone
);

  major_state_e state_q;
  major_state_e state_d;
  logic         restart;
  logic         ck_phase;
  logic         stb_phase;
  logic         last_tick;

  phase_counter #(
    .TICKS(TICKS)
  ) u_phase (
    .clk      (clk),
    .reset    (reset),
    .restart  (restart),
    .ckPhase  (ck_phase),
    .stbPhase (stb_phase),
    .lastTick (last_tick)
  );

  // next major state; transitions only on the dead tick
  always_comb begin
    state_d = state_q;
    case (state_q)
      MS_IDLE: begin
        if (run || step) state_d = MS_FETCH;
      end
      MS_FETCH: begin
        if (last_tick) begin
          if (instIsPPIND)    state_d = MS_AUTOINC1;
          else if (instIsIND) state_d = MS_INDIRECT;
          else                state_d = MS_EXEC;
        end
      end
      MS_AUTOINC1: begin
        if (last_tick) state_d = MS_AUTOINC2;
      end
      MS_AUTOINC2: begin
        if (last_tick) state_d = MS_INDIRECT;
      end
      MS_INDIRECT: begin
        if (last_tick) state_d = MS_EXEC;
      end
      MS_EXEC: begin
        if (last_tick) state_d = run ? MS_FETCH : MS_IDLE;
      end
      default: state_d = MS_IDLE;
    endcase
  end

  // every state entry starts at tick 0; IDLE holds tick 0
  assign restart = (state_d != state_q) || (state_q == MS_IDLE);

  // major state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= MS_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // gate phase strobes onto the active state's pair
  always_comb begin
    ckFetch     = 1'b0;
    stbFetch    = 1'b0;
    ckAutoinc1  = 1'b0;
    stbAutoinc1 = 1'b0;
    ckAutoinc2  = 1'b0;
    stbAutoinc2 = 1'b0;
    ckIndirect  = 1'b0;
    stbIndirect = 1'b0;
    ckExec      = 1'b0;
    stbExec     = 1'b0;
    case (state_q)
      MS_FETCH: begin
        ckFetch  = ck_phase;
        stbFetch = stb_phase;
      end
      MS_AUTOINC1: begin
        ckAutoinc1  = ck_phase;
        stbAutoinc1 = stb_phase;
      end
      MS_AUTOINC2: begin
        ckAutoinc2  = ck_phase;
        stbAutoinc2 = stb_phase;
      end
      MS_INDIRECT: begin
        ckIndirect  = ck_phase;
        stbIndirect = stb_phase;
      end
      MS_EXEC: begin
        ckExec  = ck_phase;
        stbExec = stb_phase;
      end
      default: ;
    endcase
  end

  assign majorState = state_q;
  assign busy       = (state_q != MS_IDLE);
  assign instDone   = (state_q == MS_EXEC) && last_tick;

endmodule

// File: tb/tb_major_cycle_seq.sv
// Self-checking bench for major_cycle_seq.
// Runs TICKS=4 and TICKS=3 side by side against a schedule model.
module tb_major_cycle_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic       step;
  logic       ind;
  logic       ppind;
  logic [4:0] ck4;
  logic [4:0] stb4;
  logic [4:0] ck3;
  logic [4:0] stb3;
  logic [2:0] ms4;
  logic [2:0] ms3;
  logic       busy4;
  logic       busy3;
  logic       done4;
  logic       done3;

  int checks = 0;
  int errors = 0;
  int cnt4   = 0;
  int cnt3   = 0;
  int q4[$];
  int q3[$];

  always #5 clk = ~clk;

  major_cycle_seq #(.TICKS(4)) dut4 (
    .clk(clk), .reset(reset), .run(run), .step(step),
    .instIsIND(ind), .instIsPPIND(ppind),
    .ckFetch(ck4[4]), .stbFetch(stb4[4]),
    .ckAutoinc1(ck4[3]), .stbAutoinc1(stb4[3]),
    .ckAutoinc2(ck4[2]), .stbAutoinc2(stb4[2]),
    .ckIndirect(ck4[1]), .stbIndirect(stb4[1]),
    .ckExec(ck4[0]), .stbExec(stb4[0]),
    .majorState(ms4), .busy(busy4), .instDone(done4)
  );

  major_cycle_seq #(.TICKS(3)) dut3 (
    .clk(clk), .reset(reset), .run(run), .step(step),
    .instIsIND(ind), .instIsPPIND(ppind),
    .ckFetch(ck3[4]), .stbFetch(stb3[4]),
    .ckAutoinc1(ck3[3]), .stbAutoinc1(stb3[3]),
    .ckAutoinc2(ck3[2]), .stbAutoinc2(stb3[2]),
    .ckIndirect(ck3[1]), .stbIndirect(stb3[1]),
    .ckExec(ck3[0]), .stbExec(stb3[0]),
    .majorState(ms3), .busy(busy3), .instDone(done3)
  );

  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  // schedule entry = state*16 + tick; empty schedule means IDLE
  function automatic logic [15:0] expect_out(input int t, input int e,
                                             input bit active);
    logic [4:0] ck;
    logic [4:0] stb;
    int s;
    int k;
    ck  = '0;
    stb = '0;
    if (!active) return 16'h0;
    s = e / 16;
    k = e % 16;
    if (k <= t - 2) ck[5-s] = 1'b1;
    if (k == t - 2) stb[5-s] = 1'b1;
    return {1'b0, ck, stb, 3'(s), 1'b1, (s == 5) && (k == t - 1)};
  endfunction

  task automatic push_st(ref int q[$], input int s, input int t);
    for (int k = 0; k < t; k++) q.push_back(s * 16 + k);
  endtask

  task automatic model_step(ref int q[$], input int t);
    int e;
    if (q.size() == 0) begin
      if (run || step) push_st(q, 1, t);
    end else begin
      e = q.pop_front();
      if (e == 16 + t - 1) begin
        if (ppind) begin
          push_st(q, 2, t);
          push_st(q, 3, t);
          push_st(q, 4, t);
        end else if (ind) begin
          push_st(q, 4, t);
        end
        push_st(q, 5, t);
      end else if (e == 80 + t - 1 && run) begin
        push_st(q, 1, t);
      end
    end
  endtask

  task automatic check_both();
    int e4;
    int e3;
    e4 = (q4.size() != 0) ? q4[0] : 0;
    e3 = (q3.size() != 0) ? q3[0] : 0;
    check("dut4_out", {1'b0, ck4, stb4, ms4, busy4, done4},
          expect_out(4, e4, q4.size() != 0));
    check("dut3_out", {1'b0, ck3, stb3, ms3, busy3, done3},
          expect_out(3, e3, q3.size() != 0));
  endtask

  task automatic clk_step();
    @(posedge clk);
    model_step(q4, 4);
    model_step(q3, 3);
    @(negedge clk);
    if (done4) cnt4++;
    if (done3) cnt3++;
    check_both();
  endtask

  task automatic wait_idle();
    int n;
    run  = 1'b0;
    step = 1'b0;
    n = 0;
    while ((busy4 || busy3) && n < 200) begin
      clk_step();
      n++;
    end
    if (n >= 200) check("idle_timeout", 16'd1, 16'd0);
    check("idle_busy", {14'd0, busy4, busy3}, 16'd0);
  endtask

  task automatic wait_ms4(input logic [2:0] v);
    int n;
    n = 0;
    while (ms4 != v && n < 200) begin
      clk_step();
      n++;
    end
    if (n >= 200) check("state_timeout", 16'd1, 16'd0);
  endtask

  task automatic measure(input logic i, input logic p,
                         input int exp4, input int exp3);
    int l4;
    int l3;
    l4 = 0;
    l3 = 0;
    ind   = i;
    ppind = p;
    step  = 1'b1;
    clk_step();
    step = 1'b0;
    for (int n = 1; n < 100; n++) begin
      if (done4 && l4 == 0) l4 = n;
      if (done3 && l3 == 0) l3 = n;
      if (l4 != 0 && l3 != 0) break;
      clk_step();
    end
    check("len4", 16'(l4), 16'(exp4));
    check("len3", 16'(l3), 16'(exp3));
    wait_idle();
  endtask

  initial begin
    reset = 1'b1;
    run   = 1'b0;
    step  = 1'b0;
    ind   = 1'b0;
    ppind = 1'b0;
    repeat (2) @(negedge clk);
    check_both();
    reset = 1'b0;
    repeat (3) clk_step();

    // asynchronous reset in FETCH tick 1
    run = 1'b1;
    clk_step();
    clk_step();
    #2 reset = 1'b1;
    #1;
    q4.delete();
    q3.delete();
    check_both();
    run = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check_both();
    repeat (4) clk_step();

    // back-to-back direct instructions
    cnt4 = 0;
    cnt3 = 0;
    run  = 1'b1;
    repeat (24) clk_step();
    check("b2b_done4", 16'(cnt4), 16'd3);
    check("b2b_done3", 16'(cnt3), 16'd4);
    wait_idle();

    // single-step instruction lengths
    measure(1'b0, 1'b0, 8, 6);
    measure(1'b1, 1'b0, 12, 9);
    measure(1'b1, 1'b1, 20, 15);
    measure(1'b0, 1'b1, 20, 15);

    // second step during EXEC is ignored
    cnt4  = 0;
    ind   = 1'b1;
    ppind = 1'b0;
    step  = 1'b1;
    clk_step();
    step = 1'b0;
    wait_ms4(3'd5);
    step = 1'b1;
    clk_step();
    step = 1'b0;
    wait_idle();
    check("step_once", 16'(cnt4), 16'd1);

    // run dropped during AUTOINC2
    cnt4  = 0;
    cnt3  = 0;
    ind   = 1'b0;
    ppind = 1'b1;
    run   = 1'b1;
    clk_step();
    wait_ms4(3'd3);
    run = 1'b0;
    wait_idle();
    check("drop_done4", 16'(cnt4), 16'd1);
    check("drop_done3", 16'(cnt3), 16'd1);

    // randomized run/step/flags
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 39) == 0) run = ~run;
      step  = ($urandom_range(0, 9) == 0);
      ind   = ($urandom_range(0, 2) == 0);
      ppind = ($urandom_range(0, 3) == 0);
      clk_step();
    end
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/major_cycle_seq.md
# major_cycle_seq

Major-cycle sequencer for the PDP-8 CPU. It steps each instruction through FETCH, the optional AUTOINC1/AUTOINC2/INDIRECT cycles, and EXEC. For every cycle it emits the per-cycle `ck*` (drive) and `stb*` (latch) strobes. The instruction-fetch/indirect control decoder consumes these strobes and turns them into bus and register controls. The sequencer reads back the decoded `instIsIND` and `instIsPPIND` flags to choose the path after FETCH.

## Interface
- `TICKS`, default 4, clocks per major cycle; legal range 3..8.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `run`  in  1  level; while high, instructions execute back-to-back.
- `step`  in  1  one-clock pulse; in IDLE it starts exactly one instruction.
- `instIsIND`  in  1  current IR is indirect without autoincrement; sampled at the end of FETCH.
- `instIsPPIND`  in  1  current IR is indirect through auto-index location 010–017; sampled at the end of FETCH.
- `ckFetch`, `stbFetch`  out  1 each  FETCH drive / latch strobes.
- `ckAutoinc1`, `stbAutoinc1`  out  1 each  AUTOINC1 drive / latch strobes.
- `ckAutoinc2`, `stbAutoinc2`  out  1 each  AUTOINC2 drive / latch strobes.
- `ckIndirect`, `stbIndirect`  out  1 each  INDIRECT drive / latch strobes.
- `ckExec`, `stbExec`  out  1 each  EXEC drive / latch strobes.
- `majorState`  out  3  current major state code.
- `busy`  out  1  high in any state other than IDLE.
- `instDone`  out  1  one-clock pulse on the last tick of EXEC.

## Operation
- States and codes: IDLE=0, FETCH=1, AUTOINC1=2, AUTOINC2=3, INDIRECT=4, EXEC=5. Codes 6–7 are illegal and recover to IDLE on the next edge.
- Tick counter runs 0..TICKS-1 inside every non-IDLE state and resets to 0 on each state entry.
- Strobes for the active state only:
  - `ck<state>`=1 on ticks 0..TICKS-2.
  - `stb<state>`=1 on tick TICKS-2 only.
  - Tick TICKS-1 is a dead tick: all strobes 0.
- Non-active-state strobes are always 0. At most one `ck*` and one `stb*` is high at any time.
- IDLE → FETCH when `run`=1 or `step`=1. If both are high, treat it as `run`.
- Branch at FETCH tick TICKS-1 (IR is valid after `stbFetch`):
  - `instIsPPIND`=1 → AUTOINC1 → AUTOINC2 → INDIRECT → EXEC.
  - else `instIsIND`=1 → INDIRECT → EXEC.
  - else → EXEC.
  - Both flags high: PPIND path wins.
- EXEC tick TICKS-1: pulse `instDone`.
  - Next state is FETCH if `run`=1.
  - Otherwise next state is IDLE, including after a `step`-started instruction.
- Dropping `run` mid-instruction does not abort; the instruction completes and the sequencer halts at the instruction boundary.
- `step` pulses outside IDLE are ignored.
- Reset values: state IDLE, tick 0, every output 0, `majorState`=0. Reset mid-cycle clears strobes immediately, without waiting for a clock.

## Timing
- All outputs are registered and change only on the rising edge of `clk`, or asynchronously on `reset`.
- Start latency: edge N samples `run`/`step` in IDLE. After edge N, `ckFetch`=1 and `busy`=1.
- Instruction length in clocks:
  - Direct instruction: 2·TICKS (8 at the default).
  - IND instruction: 3·TICKS (12 at the default).
  - PPIND instruction: 5·TICKS (20 at the default).
- Back-to-back instructions have no gap: FETCH tick 0 follows EXEC tick TICKS-1 directly.
- `instIsIND` and `instIsPPIND` must be stable at FETCH tick TICKS-1. They are ignored at all other times.

## Structure
- Shared `pdp8_pkg` holds:
  - the major-state enum and its codes;
  - the default-TICKS constant;
  - the tick-counter width, derived from TICKS and 3 bits for the range 3..8.
- One sub-module, `phase_counter`: tick counter with synchronous restart and asynchronous reset. It outputs `ckPhase` (ticks 0..TICKS-2), `stbPhase` (tick TICKS-2) and `lastTick` (tick TICKS-1).
- The top level holds the state register, next-state logic and the strobe fan-out, which gates the phase outputs by state.

## Test plan
- Reset mid-FETCH (tick 1), then release → all outputs 0 immediately, `majorState`=0, stays IDLE while `run`=`step`=0.
- `run`=1, flags 0, TICKS=4 → FETCH for 4 clocks (`ckFetch` on ticks 0–2, `stbFetch` on tick 2), then EXEC for 4 clocks; `instDone` pulses at clock 8; the next FETCH starts at clock 9.
- `instIsIND`=1 at FETCH end → state sequence 1,4,5; `stbIndirect` pulses exactly once; 12 clocks per instruction.
- `instIsPPIND`=1 and `instIsIND`=1 → state sequence 1,2,3,4,5; one `stb` pulse for each of Autoinc1, Autoinc2 and Indirect; 20 clocks per instruction.
- `step` pulse with `run`=0 → exactly one instruction, one `instDone`, then IDLE; a second `step` during EXEC is ignored.
- `run` dropped during AUTOINC2 → the PPIND instruction completes through EXEC, then IDLE with `busy`=0; repeat with TICKS=3 and check the strobe placement.
